// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB).
// Merges stage stall requests, sequences exception/ERET flushes behind bus drains, counts stalled cycles.
module pipeline_stall_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE  = 32'h0000000E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    input  logic        inst_bus_busy,
    input  logic        data_bus_busy,
    input  logic        perf_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        drain_active,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [5:0]  STALL_ALL = 6'b111111;
    localparam logic [31:0] CNT_MAX   = 32'hFFFFFFFF;

    state_t      state_q, state_d;
    logic [31:0] exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic [5:0]  req_stage;
    logic [5:0]  req_stall;
    logic        bus_busy;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic        drain_c;

    // Requests indexed by the stage that raises them; a request freezes its own stage and all older ones.
    assign req_stage = {1'b0, stallreq_mem, stallreq_ex, stallreq_id, stallreq_if, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_stall_merge
            assign req_stall[gi] = |req_stage[5:gi];
        end
    endgenerate

    assign bus_busy = inst_bus_busy | data_bus_busy;

    always_comb begin
        state_d  = state_q;
        exc_d    = exc_q;
        epc_d    = epc_q;
        stall_c  = '0;
        flush_c  = 1'b0;
        new_pc_c = '0;
        drain_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (excepttype != 32'd0) begin
                    if (bus_busy) begin
                        stall_c = STALL_ALL;
                        exc_d   = excepttype;
                        epc_d   = cp0_epc;
                        state_d = ST_DRAIN;
                    end else begin
                        flush_c  = 1'b1;
                        new_pc_c = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
                    end
                end else begin
                    stall_c = req_stall;
                end
            end
            ST_DRAIN: begin
                stall_c = STALL_ALL;
                drain_c = 1'b1;
                if (!bus_busy) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_c  = 1'b1;
                new_pc_c = (exc_q == ERET_CODE) ? epc_q : EXC_VECTOR;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d = '0;
        end else if ((stall_c != 6'd0) && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            exc_q          <= '0;
            epc_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            exc_q          <= exc_d;
            epc_q          <= epc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Control outputs are held quiet for as long as reset is asserted, not just after the edge.
    assign stall        = rst ? stall_c  : 6'd0;
    assign flush        = rst ? flush_c  : 1'b0;
    assign new_pc       = rst ? new_pc_c : 32'd0;
    assign drain_active = rst ? drain_c  : 1'b0;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: priority merge, immediate and drained flushes,
// reset during drain, and the saturating stall-cycle counter.
module tb_pipeline_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype, cp0_epc;
    logic        inst_bus_busy, data_bus_busy, perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        drain_active;
    logic [31:0] stall_cycles;

    int checks;
    int failures;
    logic [31:0] exp_cnt;

    pipeline_stall_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excepttype    (excepttype),
        .cp0_epc       (cp0_epc),
        .inst_bus_busy (inst_bus_busy),
        .data_bus_busy (data_bus_busy),
        .perf_clr      (perf_clr),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .drain_active  (drain_active),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stallreq_if   = 1'b0;
        stallreq_id   = 1'b0;
        stallreq_ex   = 1'b0;
        stallreq_mem  = 1'b0;
        excepttype    = 32'd0;
        cp0_epc       = 32'd0;
        inst_bus_busy = 1'b0;
        data_bus_busy = 1'b0;
        perf_clr      = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        stallreq_mem = 1'b1;
        excepttype   = 32'h8;
        #1;
        checks++;
        if ({stall, flush, drain_active} !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctrl stall=%b flush=%b drain=%b expected all 0", stall, flush, drain_active);
        end
        checks++;
        if (new_pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_new_pc got=%h expected=00000000", new_pc);
        end
        step();
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%h expected=00000000", stall_cycles);
        end
        clear_inputs();
        rst = 1'b1;
        exp_cnt = 32'd0;
        #1;
        checks++;
        if ({stall, flush, drain_active} !== 8'd0) begin
            failures++;
            $display("FAIL post_reset_idle stall=%b flush=%b drain=%b expected all 0", stall, flush, drain_active);
        end
        $display("reset: stall=%b flush=%b cnt=%0d", stall, flush, stall_cycles);
    endtask

    task automatic test_stall_priority();
        // {mem, ex, id, if} request pattern and the expected stall vector
        logic [3:0] req_vec [6];
        logic [5:0] exp_vec [6];
        req_vec[0] = 4'b0100; exp_vec[0] = 6'b001111;
        req_vec[1] = 4'b1001; exp_vec[1] = 6'b011111;
        req_vec[2] = 4'b0010; exp_vec[2] = 6'b000111;
        req_vec[3] = 4'b0001; exp_vec[3] = 6'b000011;
        req_vec[4] = 4'b0000; exp_vec[4] = 6'b000000;
        req_vec[5] = 4'b0110; exp_vec[5] = 6'b001111;
        for (int i = 0; i < 6; i++) begin
            {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req_vec[i];
            #1;
            checks++;
            if (stall !== exp_vec[i] || flush !== 1'b0) begin
                failures++;
                $display("FAIL prio_%0d stall=%b flush=%b expected stall=%b flush=0", i, stall, flush, exp_vec[i]);
            end
            step();
            if (exp_vec[i] != 6'd0) exp_cnt = exp_cnt + 32'd1;
            checks++;
            if (stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL prio_cnt_%0d got=%0d expected=%0d", i, stall_cycles, exp_cnt);
            end
            $display("prio %0d: req=%b stall=%b cnt=%0d", i, req_vec[i], stall, stall_cycles);
        end
        clear_inputs();
    endtask

    task automatic test_exc_flush();
        excepttype  = 32'h8;
        stallreq_ex = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b1 || stall !== 6'd0 || new_pc !== 32'hBFC00380 || drain_active !== 1'b0) begin
            failures++;
            $display("FAIL exc_flush flush=%b stall=%b new_pc=%h drain=%b expected 1/000000/bfc00380/0",
                     flush, stall, new_pc, drain_active);
        end
        step();
        checks++;
        if (stall_cycles !== exp_cnt) begin
            failures++;
            $display("FAIL exc_flush_cnt got=%0d expected=%0d", stall_cycles, exp_cnt);
        end
        excepttype = 32'd0;
        #1;
        checks++;
        if (stall !== 6'b001111 || flush !== 1'b0) begin
            failures++;
            $display("FAIL exc_stays_run stall=%b flush=%b expected 001111/0", stall, flush);
        end
        $display("exc_flush: new_pc=bfc00380 then stall=%b", stall);
        step();
        exp_cnt = exp_cnt + 32'd1;
        stallreq_ex = 1'b0;
        excepttype  = 32'hE;
        cp0_epc     = 32'h12345678;
        #1;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'h12345678) begin
            failures++;
            $display("FAIL eret_flush flush=%b new_pc=%h expected 1/12345678", flush, new_pc);
        end
        $display("eret_flush: new_pc=%h", new_pc);
        step();
        clear_inputs();
    endtask

    task automatic test_drain_eret();
        excepttype    = 32'hE;
        cp0_epc       = 32'h80001234;
        data_bus_busy = 1'b1;
        #1;
        checks++;
        if (stall !== 6'b111111 || flush !== 1'b0 || drain_active !== 1'b0) begin
            failures++;
            $display("FAIL drain_entry stall=%b flush=%b drain=%b expected 111111/0/0", stall, flush, drain_active);
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            excepttype    = 32'h8;
            cp0_epc       = 32'hDEADBEEF;
            stallreq_mem  = 1'b1;
            data_bus_busy = (c < 3);
            #1;
            checks++;
            if (stall !== 6'b111111 || flush !== 1'b0 || drain_active !== 1'b1) begin
                failures++;
                $display("FAIL drain_cyc_%0d stall=%b flush=%b drain=%b expected 111111/0/1",
                         c, stall, flush, drain_active);
            end
            $display("drain cycle %0d: stall=%b drain=%b", c, stall, drain_active);
        end
        step();
        exp_cnt = exp_cnt + 32'd4;
        clear_inputs();
        #1;
        checks++;
        if (flush !== 1'b1 || stall !== 6'd0 || new_pc !== 32'h80001234 || drain_active !== 1'b0) begin
            failures++;
            $display("FAIL drain_flush flush=%b stall=%b new_pc=%h drain=%b expected 1/000000/80001234/0",
                     flush, stall, new_pc, drain_active);
        end
        checks++;
        if (stall_cycles !== exp_cnt) begin
            failures++;
            $display("FAIL drain_cnt got=%0d expected=%0d", stall_cycles, exp_cnt);
        end
        step();
        #1;
        checks++;
        if (flush !== 1'b0 || stall !== 6'd0 || drain_active !== 1'b0) begin
            failures++;
            $display("FAIL drain_back_run flush=%b stall=%b drain=%b expected 0/000000/0", flush, stall, drain_active);
        end
        $display("drain_eret: flush new_pc=80001234, back to run");
    endtask

    task automatic test_reset_in_drain();
        excepttype    = 32'h8;
        inst_bus_busy = 1'b1;
        step();
        #1;
        checks++;
        if (drain_active !== 1'b1) begin
            failures++;
            $display("FAIL rdrain_enter drain=%b expected 1", drain_active);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({stall, flush, drain_active} !== 8'd0 || new_pc !== 32'd0) begin
            failures++;
            $display("FAIL rdrain_forced stall=%b flush=%b drain=%b new_pc=%h expected all 0",
                     stall, flush, drain_active, new_pc);
        end
        clear_inputs();
        step();
        rst = 1'b1;
        exp_cnt = 32'd0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (flush !== 1'b0 || stall !== 6'd0 || drain_active !== 1'b0 || stall_cycles !== exp_cnt) begin
                failures++;
                $display("FAIL rdrain_after_%0d flush=%b stall=%b drain=%b cnt=%0d expected 0/000000/0/%0d",
                         c, flush, stall, drain_active, stall_cycles, exp_cnt);
            end
            step();
        end
        $display("reset_in_drain: run with no flush");
    endtask

    task automatic test_inst_busy_toggle();
        excepttype    = 32'h8;
        inst_bus_busy = 1'b1;
        data_bus_busy = 1'b1;
        #1;
        checks++;
        if (stall !== 6'b111111 || drain_active !== 1'b0) begin
            failures++;
            $display("FAIL tog_entry stall=%b drain=%b expected 111111/0", stall, drain_active);
        end
        for (int c = 1; c <= 5; c++) begin
            step();
            excepttype    = 32'd0;
            inst_bus_busy = (c < 5);
            data_bus_busy = (c < 5) ? c[0] : 1'b0;
            #1;
            checks++;
            if (stall !== 6'b111111 || drain_active !== 1'b1 || flush !== 1'b0) begin
                failures++;
                $display("FAIL tog_drain_%0d stall=%b drain=%b flush=%b expected 111111/1/0",
                         c, stall, drain_active, flush);
            end
        end
        step();
        exp_cnt = exp_cnt + 32'd6;
        #1;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC00380 || stall !== 6'd0) begin
            failures++;
            $display("FAIL tog_flush flush=%b new_pc=%h stall=%b expected 1/bfc00380/000000", flush, new_pc, stall);
        end
        step();
        #1;
        checks++;
        if (flush !== 1'b0 || stall !== 6'd0 || drain_active !== 1'b0 || stall_cycles !== exp_cnt) begin
            failures++;
            $display("FAIL tog_run flush=%b stall=%b drain=%b cnt=%0d expected 0/000000/0/%0d",
                     flush, stall, drain_active, stall_cycles, exp_cnt);
        end
        $display("inst_busy_toggle: flush N+1, run N+2, cnt=%0d", stall_cycles);
        clear_inputs();
    endtask

    task automatic test_saturation();
        stallreq_if = 1'b1;
        force dut.stall_cycles_q = 32'hFFFFFFFE;
        #1;
        release dut.stall_cycles_q;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (stall_cycles !== 32'hFFFFFFFF) begin
                failures++;
                $display("FAIL sat_%0d got=%h expected=ffffffff", c, stall_cycles);
            end
        end
        perf_clr = 1'b1;
        step();
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL perf_clr got=%h expected=00000000", stall_cycles);
        end
        perf_clr = 1'b0;
        step();
        checks++;
        if (stall_cycles !== 32'd1) begin
            failures++;
            $display("FAIL post_clr got=%h expected=00000001", stall_cycles);
        end
        stallreq_if = 1'b0;
        step();
        checks++;
        if (stall_cycles !== 32'd1) begin
            failures++;
            $display("FAIL idle_hold got=%h expected=00000001", stall_cycles);
        end
        $display("saturation: sticks at ffffffff, clear to 0, cnt=%0d", stall_cycles);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 32'd0;
        rst      = 1'b0;
        clear_inputs();
        test_reset();
        test_stall_priority();
        test_exc_flush();
        test_drain_eret();
        test_reset_in_drain();
        test_inst_busy_toggle();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
